// File: rtl/asrv32_writeback_pipe_pkg.sv
// ASRV32 shared header: one-hot opcode indices, load funct3 codes,
// trap cause and the opcode class decoder used by the writeback stage.
package asrv32_writeback_pipe_pkg;

    localparam int OPCODE_RTYPE  = 0;
    localparam int OPCODE_ITYPE  = 1;
    localparam int OPCODE_LOAD   = 2;
    localparam int OPCODE_STORE  = 3;
    localparam int OPCODE_BRANCH = 4;
    localparam int OPCODE_JAL    = 5;
    localparam int OPCODE_JALR   = 6;
    localparam int OPCODE_LUI    = 7;
    localparam int OPCODE_AUIPC  = 8;
    localparam int OPCODE_SYSTEM = 9;
    localparam int OPCODE_FENCE  = 10;
    localparam int OPCODE_WIDTH  = 11;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam int CAUSE_INSTR_MISALIGNED = 0;

    typedef struct packed {
        logic is_alu;
        logic is_load;
        logic is_branch;
        logic is_jal;
        logic is_jalr;
        logic is_lui;
        logic is_auipc;
        logic no_rd;
    } op_dec_t;

    function automatic op_dec_t decode_op(
        input logic [OPCODE_WIDTH-1:0] op
    );
        op_dec_t d;
        d.is_alu    = op[OPCODE_RTYPE] | op[OPCODE_ITYPE];
        d.is_load   = op[OPCODE_LOAD];
        d.is_branch = op[OPCODE_BRANCH];
        d.is_jal    = op[OPCODE_JAL];
        d.is_jalr   = op[OPCODE_JALR];
        d.is_lui    = op[OPCODE_LUI];
        d.is_auipc  = op[OPCODE_AUIPC];
        d.no_rd     = op[OPCODE_BRANCH] | op[OPCODE_STORE]
                    | op[OPCODE_SYSTEM] | op[OPCODE_FENCE];
        return d;
    endfunction

endpackage

// File: rtl/asrv32_writeback_pipe_if.sv
// Memory-stage to writeback-stage bundle: valid/ready handshake,
// executed instruction fields and the late load-data return.
interface asrv32_writeback_pipe_if #(
    parameter int XLEN = 32
);
    import asrv32_writeback_pipe_pkg::*;

    logic                    valid;
    logic                    ready;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [2:0]              funct3;
    logic [4:0]              rd_addr;
    logic [XLEN-1:0]         result_from_alu;
    logic [XLEN-1:0]         imm;
    logic [XLEN-1:0]         rs1_data;
    logic [1:0]              load_addr_lsb;
    logic [XLEN-1:0]         load_data;
    logic                    load_valid;

    modport master (
        output valid, opcode, funct3, rd_addr,
        output result_from_alu, imm, rs1_data,
        output load_addr_lsb, load_data, load_valid,
        input  ready
    );

    modport slave (
        input  valid, opcode, funct3, rd_addr,
        input  result_from_alu, imm, rs1_data,
        input  load_addr_lsb, load_data, load_valid,
        output ready
    );

endinterface

// File: rtl/asrv32_load_align.sv
// Load data alignment: byte/halfword lane select from the address
// low bits, then sign or zero extension chosen by funct3.
module asrv32_load_align
    import asrv32_writeback_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      lsb,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        unique case (lsb)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = lsb[1] ? data[31:16] : data[15:0];
        // Reserved encodings fall through to a full-word load
        unique case (funct3)
            LOAD_LB:  result = {{(XLEN-8){b[7]}}, b};
            LOAD_LH:  result = {{(XLEN-16){h[15]}}, h};
            LOAD_LBU: result = {{(XLEN-8){1'b0}}, b};
            LOAD_LHU: result = {{(XLEN-16){1'b0}}, h};
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/asrv32_writeback_pipe.sv
// ASRV32 writeback/commit stage: waits for late load data, computes
// next PC and rd value, flags misaligned targets, counts retirement.
module asrv32_writeback_pipe
    import asrv32_writeback_pipe_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] PC_RESET    = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0004),
    parameter int              CNT_WIDTH   = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    asrv32_writeback_pipe_if.slave mem,
    output logic [XLEN-1:0]      o_rd_data,
    output logic [4:0]           o_rd_addr,
    output logic                 o_wr_rd_en,
    output logic [XLEN-1:0]      o_pc,
    output logic                 o_retire,
    output logic                 o_trap,
    output logic [XLEN-1:0]      o_trap_tval,
    output logic [CNT_WIDTH-1:0] o_instret
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0] state;

    logic [OPCODE_WIDTH-1:0] h_opcode;
    logic [2:0]              h_funct3;
    logic [4:0]              h_rd;
    logic [XLEN-1:0]         h_alu;
    logic [XLEN-1:0]         h_imm;
    logic [XLEN-1:0]         h_rs1;
    logic [1:0]              h_lsb;

    logic [OPCODE_WIDTH-1:0] c_opcode;
    logic [2:0]              c_funct3;
    logic [4:0]              c_rd;
    logic [XLEN-1:0]         c_alu;
    logic [XLEN-1:0]         c_imm;
    logic [XLEN-1:0]         c_rs1;
    logic [1:0]              c_lsb;

    op_dec_t         dec;
    logic            wait_st;
    logic            accept;
    logic            hold;
    logic            commit;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] ld_val;
    logic [XLEN-1:0] rd_val;
    logic            taken;
    logic            trap;
    logic            wr_en;

    assign wait_st   = (state == S_WAIT);
    assign mem.ready = !wait_st;
    assign accept    = !wait_st && mem.valid;
    assign hold      = accept && mem.opcode[OPCODE_LOAD]
                     && !mem.load_valid;
    assign commit    = (accept && !hold)
                     || (wait_st && mem.load_valid);

    // A parked load commits from its held fields, anything else live
    assign c_opcode = wait_st ? h_opcode : mem.opcode;
    assign c_funct3 = wait_st ? h_funct3 : mem.funct3;
    assign c_rd     = wait_st ? h_rd     : mem.rd_addr;
    assign c_alu    = wait_st ? h_alu    : mem.result_from_alu;
    assign c_imm    = wait_st ? h_imm    : mem.imm;
    assign c_rs1    = wait_st ? h_rs1    : mem.rs1_data;
    assign c_lsb    = wait_st ? h_lsb    : mem.load_addr_lsb;

    assign dec = decode_op(c_opcode);

    asrv32_load_align #(
        .XLEN   (XLEN)
    ) u_load_align (
        .data   (mem.load_data),
        .lsb    (c_lsb),
        .funct3 (c_funct3),
        .result (ld_val)
    );

    always_comb begin
        base    = dec.is_jalr ? c_rs1 : o_pc;
        sum     = base + c_imm;
        target  = dec.is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
        pc_inc  = o_pc + XLEN'(4);
        taken   = dec.is_jal || dec.is_jalr
                || (dec.is_branch && c_alu[0]);
        trap    = taken && target[1];
        next_pc = trap  ? TRAP_VECTOR :
                  taken ? target      : pc_inc;
        wr_en   = !dec.no_rd && (c_rd != 5'd0) && !trap;
        unique case (1'b1)
            dec.is_jal,
            dec.is_jalr:  rd_val = pc_inc;
            dec.is_lui:   rd_val = c_imm;
            dec.is_auipc: rd_val = sum;
            dec.is_load:  rd_val = ld_val;
            dec.is_alu:   rd_val = c_alu;
            default:      rd_val = c_alu;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (hold) begin
            h_opcode <= mem.opcode;
            h_funct3 <= mem.funct3;
            h_rd     <= mem.rd_addr;
            h_alu    <= mem.result_from_alu;
            h_imm    <= mem.imm;
            h_rs1    <= mem.rs1_data;
            h_lsb    <= mem.load_addr_lsb;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_pc        <= PC_RESET;
            o_rd_data   <= '0;
            o_rd_addr   <= '0;
            o_wr_rd_en  <= 1'b0;
            o_retire    <= 1'b0;
            o_trap      <= 1'b0;
            o_trap_tval <= '0;
            o_instret   <= '0;
        end else begin
            o_wr_rd_en <= 1'b0;
            o_retire   <= 1'b0;
            o_trap     <= 1'b0;
            if (hold) begin
                state <= S_WAIT;
            end
            if (commit) begin
                state      <= S_IDLE;
                o_pc       <= next_pc;
                o_rd_data  <= rd_val;
                o_rd_addr  <= c_rd;
                o_wr_rd_en <= wr_en;
                o_retire   <= !trap;
                o_trap     <= trap;
                if (trap) begin
                    o_trap_tval <= target;
                end else begin
                    o_instret <= o_instret + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_asrv32_writeback_pipe.sv
// Bench for asrv32_writeback_pipe: directed vector table, reset during
// a pending load, then random instructions against a reference model.
module tb_asrv32_writeback_pipe;
    import asrv32_writeback_pipe_pkg::*;

    localparam logic [31:0] TV = 32'h0000_0004;

    typedef struct {
        int          op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [1:0]  lsb;
        logic [31:0] data;
        int          dly;
        logic [31:0] e_rd;
        logic        e_wr;
        logic [31:0] e_pc;
        logic        e_trap;
        logic [31:0] e_tval;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr;
    logic        wr_en;
    logic [31:0] pc;
    logic        retire;
    logic        trap;
    logic [31:0] tval;
    logic [63:0] instret;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [63:0] exp_instret = 64'h0;
    vec_t        tbl[$];

    asrv32_writeback_pipe_if #(.XLEN(32)) mem ();

    asrv32_writeback_pipe dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .mem         (mem),
        .o_rd_data   (rd_data),
        .o_rd_addr   (rd_addr),
        .o_wr_rd_en  (wr_en),
        .o_pc        (pc),
        .o_retire    (retire),
        .o_trap      (trap),
        .o_trap_tval (tval),
        .o_instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input int op, input logic [2:0] f3, input logic [4:0] rd,
        input logic [31:0] alu, input logic [31:0] imm,
        input logic [31:0] rs1, input logic [1:0] lsb,
        input logic [31:0] data, input int dly,
        input logic [31:0] e_rd, input logic e_wr,
        input logic [31:0] e_pc, input logic e_trap,
        input logic [31:0] e_tval
    );
        vec_t v;
        v.op = op; v.f3 = f3; v.rd = rd; v.alu = alu;
        v.imm = imm; v.rs1 = rs1; v.lsb = lsb; v.data = data;
        v.dly = dly; v.e_rd = e_rd; v.e_wr = e_wr;
        v.e_pc = e_pc; v.e_trap = e_trap; v.e_tval = e_tval;
        return v;
    endfunction

    function automatic logic [31:0] ref_load(
        input logic [2:0] f3, input logic [1:0] lsb,
        input logic [31:0] data
    );
        logic [31:0] b;
        logic [31:0] h;
        b = (data >> (8 * lsb)) & 32'hFF;
        h = (data >> (16 * lsb[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return data;
        endcase
    endfunction

    function automatic vec_t model(input vec_t v, input logic [31:0] cur);
        vec_t        r;
        logic [31:0] s;
        logic [31:0] t;
        logic        tk;
        r  = v;
        s  = ((v.op == OPCODE_JALR) ? v.rs1 : cur) + v.imm;
        t  = (v.op == OPCODE_JALR) ? (s & 32'hFFFF_FFFE) : s;
        tk = (v.op == OPCODE_JAL) || (v.op == OPCODE_JALR)
           || ((v.op == OPCODE_BRANCH) && v.alu[0]);
        r.e_trap = tk && ((t % 4) >= 2);
        r.e_tval = t;
        r.e_pc   = r.e_trap ? TV : (tk ? t : cur + 32'd4);
        if (v.op == OPCODE_JAL || v.op == OPCODE_JALR) r.e_rd = cur + 32'd4;
        else if (v.op == OPCODE_LUI)   r.e_rd = v.imm;
        else if (v.op == OPCODE_AUIPC) r.e_rd = s;
        else if (v.op == OPCODE_LOAD)  r.e_rd = ref_load(v.f3, v.lsb, v.data);
        else                           r.e_rd = v.alu;
        r.e_wr = !(v.op == OPCODE_BRANCH || v.op == OPCODE_STORE
                || v.op == OPCODE_SYSTEM || v.op == OPCODE_FENCE)
                && (v.rd != 0) && !r.e_trap;
        return r;
    endfunction

    task automatic scramble();
        mem.valid           = 1'($urandom);
        mem.opcode          = OPCODE_WIDTH'(1) << $urandom_range(0, 10);
        mem.funct3          = 3'($urandom);
        mem.rd_addr         = 5'($urandom);
        mem.result_from_alu = $urandom;
        mem.imm             = $urandom;
        mem.rs1_data        = $urandom;
        mem.load_addr_lsb   = 2'($urandom);
    endtask

    task automatic run(input vec_t v);
        logic is_ld;
        is_ld               = (v.op == OPCODE_LOAD);
        mem.valid           = 1'b1;
        mem.opcode          = OPCODE_WIDTH'(1) << v.op;
        mem.funct3          = v.f3;
        mem.rd_addr         = v.rd;
        mem.result_from_alu = v.alu;
        mem.imm             = v.imm;
        mem.rs1_data        = v.rs1;
        mem.load_addr_lsb   = v.lsb;
        mem.load_valid      = is_ld ? (v.dly == 0) : 1'($urandom);
        mem.load_data       = (is_ld && v.dly != 0) ? $urandom : v.data;
        @(posedge clk); #1;
        for (int k = 0; is_ld && k < v.dly; k++) begin
            chk("ready_wait", mem.ready, 0);
            chk("retire_wait", retire, 0);
            scramble();
            mem.load_valid = (k == v.dly - 1);
            mem.load_data  = (k == v.dly - 1) ? v.data : $urandom;
            @(posedge clk); #1;
        end
        mem.valid      = 1'b0;
        mem.load_valid = 1'b0;
        exp_pc = v.e_pc;
        if (!v.e_trap) exp_instret++;
        chk("wr_en", wr_en, v.e_wr);
        chk("retire", retire, !v.e_trap);
        chk("trap", trap, v.e_trap);
        chk("pc", pc, exp_pc);
        chk("instret", instret, exp_instret);
        chk("ready", mem.ready, 1);
        if (v.e_wr) begin
            chk("rd_data", rd_data, v.e_rd);
            chk("rd_addr", rd_addr, v.rd);
        end
        if (v.e_trap) chk("trap_tval", tval, v.e_tval);
        mem.load_valid = 1'($urandom);
        @(posedge clk); #1;
        mem.load_valid = 1'b0;
        chk("gap_strobes", {wr_en, retire, trap}, 0);
        chk("gap_pc", pc, exp_pc);
    endtask

    initial begin
        vec_t v;
        mem.valid = 0; mem.opcode = '0; mem.funct3 = '0;
        mem.rd_addr = '0; mem.result_from_alu = '0; mem.imm = '0;
        mem.rs1_data = '0; mem.load_addr_lsb = '0;
        mem.load_data = '0; mem.load_valid = 0;

        tbl.push_back(mk(OPCODE_JAL, 0, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0));
        tbl.push_back(mk(OPCODE_ITYPE, 0, 5, 32'h2A, 0, 0, 0, 0, 0, 32'h2A, 1, 32'h104, 0, 0));
        tbl.push_back(mk(OPCODE_LOAD, 3'b000, 6, 0, 0, 0, 2, 32'h0080_0000, 3, 32'hFFFF_FF80, 1, 32'h108, 0, 0));
        tbl.push_back(mk(OPCODE_JAL, 0, 0, 0, 32'hFFFF_FF38, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0));
        tbl.push_back(mk(OPCODE_JALR, 0, 1, 0, 0, 32'h201, 0, 0, 0, 32'h44, 1, 32'h200, 0, 0));
        tbl.push_back(mk(OPCODE_JALR, 0, 1, 0, 0, 32'h202, 0, 0, 0, 0, 0, TV, 1, 32'h202));
        tbl.push_back(mk(OPCODE_JAL, 0, 0, 0, 32'h1C, 0, 0, 0, 0, 0, 0, 32'h20, 0, 0));
        tbl.push_back(mk(OPCODE_BRANCH, 0, 4, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0, 32'h18, 0, 0));
        tbl.push_back(mk(OPCODE_BRANCH, 0, 4, 0, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0, 32'h1C, 0, 0));
        tbl.push_back(mk(OPCODE_RTYPE, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0, 0));
        tbl.push_back(mk(OPCODE_LUI, 0, 3, 0, 32'hABCD_E000, 0, 0, 0, 0, 32'hABCD_E000, 1, 32'h24, 0, 0));
        tbl.push_back(mk(OPCODE_LOAD, 3'b100, 7, 0, 0, 0, 3, 32'h8000_0000, 0, 32'h80, 1, 32'h28, 0, 0));
        tbl.push_back(mk(OPCODE_LOAD, 3'b001, 8, 0, 0, 0, 2, 32'h8001_0000, 1, 32'hFFFF_8001, 1, 32'h2C, 0, 0));
        tbl.push_back(mk(OPCODE_LOAD, 3'b101, 8, 0, 0, 0, 0, 32'h1234_F00F, 2, 32'h0000_F00F, 1, 32'h30, 0, 0));
        tbl.push_back(mk(OPCODE_LOAD, 3'b010, 9, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1, 32'h34, 0, 0));
        tbl.push_back(mk(OPCODE_AUIPC, 0, 9, 0, 32'h1000, 0, 0, 0, 0, 32'h1034, 1, 32'h38, 0, 0));
        tbl.push_back(mk(OPCODE_STORE, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3C, 0, 0));
        tbl.push_back(mk(OPCODE_BRANCH, 0, 0, 1, 32'h6, 0, 0, 0, 0, 0, 0, TV, 1, 32'h42));
        tbl.push_back(mk(OPCODE_JAL, 0, 1, 0, 32'h2, 0, 0, 0, 0, 0, 0, TV, 1, 32'h6));
        tbl.push_back(mk(OPCODE_LOAD, 3'b011, 11, 0, 0, 0, 2, 32'h89AB_CDEF, 1, 32'h89AB_CDEF, 1, 32'h8, 0, 0));
        tbl.push_back(mk(OPCODE_SYSTEM, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0, 0));
        tbl.push_back(mk(OPCODE_FENCE, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ready", mem.ready, 1);
        chk("rst_instret", instret, 0);
        chk("rst_strobes", {wr_en, retire, trap}, 0);
        chk("rst_rd", {rd_data, rd_addr, tval}, 0);
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i]);

        mem.valid      = 1'b1;
        mem.opcode     = OPCODE_WIDTH'(1) << OPCODE_LOAD;
        mem.funct3     = LOAD_LW;
        mem.rd_addr    = 5'd5;
        mem.load_valid = 1'b0;
        @(posedge clk); #1;
        mem.valid = 1'b0;
        chk("rstw_ready_before", mem.ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstw_ready", mem.ready, 1);
        chk("rstw_pc", pc, 32'h0);
        chk("rstw_instret", instret, 0);
        mem.load_valid = 1'b1;
        mem.load_data  = 32'h1234_5678;
        @(posedge clk); #1;
        mem.load_valid = 1'b0;
        chk("rstw_late_strobes", {wr_en, retire, trap}, 0);
        chk("rstw_late_pc", pc, 32'h0);
        chk("rstw_late_instret", instret, 0);
        exp_pc = 32'h0;
        exp_instret = 64'h0;

        for (int n = 0; n < 200; n++) begin
            v.op   = $urandom_range(0, 10);
            v.f3   = 3'($urandom);
            v.rd   = 5'($urandom);
            v.alu  = $urandom;
            v.imm  = ($urandom_range(0, 1) == 1) ? $urandom
                   : (32'($urandom_range(0, 255)) << 1);
            v.rs1  = $urandom;
            v.lsb  = 2'($urandom);
            v.data = $urandom;
            v.dly  = $urandom_range(0, 3);
            v = model(v, exp_pc);
            run(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/asrv32_writeback_pipe.md
Name: asrv32_writeback_pipe

Overview:
- Parametrised next-generation writeback/commit stage for the ASRV32 core.
- Accepts one decoded/executed instruction per handshake from the memory stage and waits for late load data.
- Aligns and sign-extends load data, computes next PC with one shared adder, detects misaligned control-flow targets (trap redirect), writes rd and counts retired instructions.
- Sits between the memory stage and the register file / fetch PC.

Parameters:
- XLEN, 32, datapath width for rd, PC, imm, rs1 and the ALU result.
- PC_RESET, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0004, PC loaded on a misaligned-target trap.
- CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept an instruction.
- i_opcode  in  OPCODE_WIDTH  one-hot opcode; bit indices OPCODE_RTYPE…OPCODE_FENCE from the shared header.
- i_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_rd_addr  in  5  destination register index.
- i_result_from_alu  in  XLEN  ALU result; bit0 is the branch-taken flag.
- i_imm  in  XLEN  immediate.
- i_rs1_data  in  XLEN  rs1 value.
- i_load_addr_lsb  in  2  low bits of the load address.
- i_load_data  in  XLEN  raw memory word.
- i_load_valid  in  1  i_load_data valid this cycle.
- o_rd_data  out  XLEN  rd write data.
- o_rd_addr  out  5  rd write index.
- o_wr_rd_en  out  1  one-cycle rd write strobe.
- o_pc  out  XLEN  current committed PC.
- o_retire  out  1  one-cycle pulse per retired instruction.
- o_trap  out  1  one-cycle misaligned-target trap pulse.
- o_trap_tval  out  XLEN  offending target address.
- o_instret  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (synchronous, i_rst=1): o_pc=PC_RESET; o_rd_data=0, o_rd_addr=0, o_wr_rd_en=0, o_retire=0, o_trap=0, o_trap_tval=0, o_instret=0; FSM→IDLE; any held instruction is dropped.
- Reset mid-WAIT_LOAD: the held instruction is discarded and never retires.
- FSM, IDLE:
  - o_ready=1.
  - On i_valid with a load opcode and !i_load_valid: capture all inputs into a holding register, go to WAIT_LOAD.
  - Otherwise, on i_valid, commit at the next edge.
- FSM, WAIT_LOAD:
  - o_ready=0.
  - When i_load_valid=1: commit using the held fields and the current i_load_data, return to IDLE.
- Commit latency: 1 cycle after the accept edge (or after the i_load_valid edge). All outputs are registered.
- Strobe rules: o_wr_rd_en, o_retire and o_trap are high exactly one cycle per commit and 0 otherwise.
- Shared adder: sum = base + imm. base = rs1 for JALR, PC otherwise.
- Target: sum for JAL/BRANCH; sum with bit0 forced to 0 for JALR.
- Next PC and rd by opcode:
  - Taken branch (ALU bit0=1): PC ← target.
  - JAL/JALR: rd=PC+4, PC ← target.
  - LUI: rd=imm.
  - AUIPC: rd=sum.
  - RTYPE/ITYPE: rd=ALU result.
  - LOAD: rd=extracted data.
  - Any other case: PC ← PC+4. All PC arithmetic wraps mod 2^XLEN.
- Load extraction:
  - Byte select = i_load_addr_lsb.
  - Halfword select = lsb[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Unlisted funct3 is treated as LW.
- rd write enable: o_wr_rd_en=1 except for BRANCH, STORE, SYSTEM, FENCE, rd_addr==0, or a trap.
- Trap: on taken BRANCH/JAL/JALR where target[1]=1:
  - o_trap=1, o_trap_tval=target, o_pc=TRAP_VECTOR.
  - No rd write, no retire.
- o_instret increments by 1 on every o_retire and wraps at 2^CNT_WIDTH.
- Simultaneous accept and i_load_valid in IDLE: commit directly, no WAIT_LOAD.
- i_load_valid outside a pending load is ignored.

Decomposition:
- Shared header: OPCODE_* indices and OPCODE_WIDTH (existing), plus new funct3 load encodings LOAD_LB…LOAD_LHU and the trap cause constant CAUSE_INSTR_MISALIGNED (0).
- One natural sub-module: asrv32_load_align, a combinational byte/half select and extend, parametrised by XLEN.

Test Plan:
- ITYPE: ALU=0x2A, rd=5, PC=0x100, valid in IDLE → next cycle o_rd_data=0x2A, o_wr_rd_en=1, o_pc=0x104, o_instret=1.
- LB, lsb=2, data=0x0080_0000, i_load_valid 3 cycles late → o_ready=0 for 3 cycles, then o_rd_data=0xFFFF_FF80, o_pc+=4.
- JALR: rs1=0x201, imm=0x0, PC=0x40, rd=1 → o_rd_data=0x44, o_pc=0x200; repeat with rs1=0x202 → o_trap=1, o_trap_tval=0x202, o_pc=TRAP_VECTOR, no write, no retire.
- BRANCH taken: ALU=1, imm=-8, PC=0x20 → o_pc=0x18, o_wr_rd_en=0; same with ALU=0 → o_pc=0x24.
- ADD with rd=0 → o_wr_rd_en=0, o_retire=1; LUI imm=0xABCD_E000, rd=3 → o_rd_data=0xABCD_E000.
- i_rst=1 asserted while in WAIT_LOAD → next cycle o_ready=1, o_pc=PC_RESET, o_instret=0; a late i_load_valid produces no commit.
